// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared handshake types and counting helpers
package handshake_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } occ_e;

  localparam int unsigned SAT_MAX_WIDTH = 32;

  // Saturates at 2^width-1; value is zero-extended into 32 bits by the caller.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [SAT_MAX_WIDTH-1:0] max_val;
    if (width >= SAT_MAX_WIDTH) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/handshake_elastic_buf2.sv
// rtl/handshake_elastic_buf2.sv - 2-slot FIFO elastic buffer with registered ready
module handshake_elastic_buf2
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          state_d = BUF_ONE;
          head_d  = in_data;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          state_d = BUF_TWO;
          tail_d  = in_data;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready_q is low here, so only a pop can happen
        if (pop) begin
          state_d = BUF_ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    in_ready_d = (state_d != BUF_TWO);
  end

  always_comb begin
    out_valid = (state_q != BUF_EMPTY);
    out_data  = out_valid ? head_q : '0;
    in_ready  = in_ready_q;
  end

endmodule

// File: rtl/handshake_constant_match.sv
// rtl/handshake_constant_match.sv - compares data tokens to a constant, emits a 1-bit match token
module handshake_constant_match
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  mismatch_count
);

  localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_VALUE);

  logic                 match;
  logic                 in_xfer;
  logic [0:0]           buf_out;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign match   = (ins == CONST_W);
  assign in_xfer = ins_valid && ins_ready;

  handshake_elastic_buf2 #(
    .WIDTH (1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .in_data   (match),
    .in_valid  (ins_valid),
    .in_ready  (ins_ready),
    .out_data  (buf_out),
    .out_valid (outs_valid),
    .out_ready (outs_ready)
  );

  assign outs = buf_out[0];

  // Counts at acceptance time, so output backpressure never affects it
  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer && !match) begin
      cnt_d = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(cnt_q), CNT_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mismatch_count = cnt_q;

endmodule
